data_mem_ws: RTL

- Parametrised, big-endian, byte-addressed data memory for the vcpu data path.
- Successor to the fixed 8 KB word-only data memory.
- Adds byte/halfword/word access with sign or zero extension on loads.
- Adds a programmable wait-state count, a req/ready/done handshake, and alignment and range error reporting.
- Sits between the CPU memory stage and the data store; the memory stage stalls while ready is low.

---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_mem_ws_align.sv | 26 ++
 rtl/data_mem_ws.sv | 68 ++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size codes, FSM states and request record shared by the data memory.
package data_mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;
endpackage

// File: rtl/data_mem_ws_align.sv
// mem_align: big-endian lane steering, alignment check and load extension.
module mem_align
   import data_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sext,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic        err_align,
   output logic [31:0] ldata
);
   logic [7:0]  b;
   logic [15:0] h;
   // be[i] is byte offset i, which lives in rword/wlane bits [8*(3-i) +: 8]
   always_comb begin
      b = rword[{~off, 3'b000} +: 8];
      h = rword[{~off[1], 4'b0000} +: 16];
      be = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : size == SZ_WORD ? 4'b1111 : 4'b0000;
      wlane = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
      err_align = (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == SZ_RSVD;
      ldata = size == SZ_BYTE ? {{24{sext && b[7]}}, b} : size == SZ_HALF ? {{16{sext && h[15]}}, h} : size == SZ_WORD ? rword : 32'h0;
   end
endmodule

// File: rtl/data_mem_ws.sv
// data_mem_ws: big-endian byte-addressed data memory with wait states and req/ready/done handshake.
module data_mem_ws
   import data_mem_pkg::*;
#(
   parameter int DEPTH_BYTES = 8192,
   parameter int ADDR_W      = 13,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err_align,
   output logic        err_range
);
   state_t            state, state_nx;
   logic [3:0]        cnt;
   req_t              lat, cur;
   logic              accept, commit, e_al, e_rg;
   logic [3:0]        be;
   logic [31:0]       wlane, rword, ldata;
   logic [ADDR_W-3:0] widx;
   logic [7:0]        mem [DEPTH_BYTES];
   assign ready = state != S_WAIT;
   assign done  = state == S_RESP;
   // Zero wait states commit on the acceptance edge straight from the inputs
   always_comb begin
      accept = req && ready;
      cur = state == S_WAIT ? lat : {wr, size, sext, addr, wdata};
      commit = state == S_WAIT ? cnt == 4'd1 : accept && WAIT_CYCLES == 0;
      state_nx = state == S_WAIT ? (cnt == 4'd1 ? S_RESP : S_WAIT) : accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE;
      e_rg = (cur.addr >> ADDR_W) != 32'h0;
      widx = cur.addr[ADDR_W-1:2];
      rword = {mem[{widx, 2'd0}], mem[{widx, 2'd1}], mem[{widx, 2'd2}], mem[{widx, 2'd3}]};
   end
   mem_align u_align (
      .size(cur.size), .off(cur.addr[1:0]), .sext(cur.sext), .wdata(cur.wdata), .rword(rword),
      .be(be), .wlane(wlane), .err_align(e_al), .ldata(ldata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt       <= 4'd0;
         lat       <= '0;
         rdata     <= 32'h0;
         err_align <= 1'b0;
         err_range <= 1'b0;
      end else begin
         if (accept) lat <= cur;
         cnt       <= state == S_WAIT ? cnt - 4'd1 : accept ? 4'(WAIT_CYCLES) : 4'd0;
         err_align <= commit && e_al;
         err_range <= commit && e_rg;
         if (commit) rdata <= (cur.wr || e_al || e_rg) ? 32'h0 : ldata;
      end
   always_ff @(posedge clk)
      if (commit && cur.wr && !e_al && !e_rg && !rst)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[{widx, 2'(i)}] <= wlane[8*(3-i) +: 8];
endmodule
